// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared encodings for the load/store path: decode command codes, access
// size classes, load sign selection, LSU exception causes and LSU states.
// No ports; imported by cpu_lsu_ctrl and lsu_lane_align.
package cpu_mem_pkg;

  // Decode command field
  localparam logic [1:0] LW_CMD  = 2'b11;
  localparam logic [1:0] ST_CMD  = 2'b10;
  localparam logic [1:0] JMP_CMD = 2'b01;
  localparam logic [1:0] OTHER   = 2'b00;

  // Access size class (the "be" field from decode)
  localparam logic [1:0] FULL  = 2'b00;
  localparam logic [1:0] HALF  = 2'b01;
  localparam logic [1:0] BYTE  = 2'b10;
  localparam logic [1:0] UPPER = 2'b11;

  // Load extension select
  localparam logic SIGN   = 1'b1;
  localparam logic UNSIGN = 1'b0;

  // Exception causes
  localparam logic [1:0] EXC_MISALIGN = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_BUSERR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Halfwords need an even address, full words a word-aligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      HALF:    mis = lo[0];
      FULL:    mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
// Combinational byte-lane steering for a 32-bit little-endian data bus.
// Ports:
//   size, sign, lane  - access size class, load sign select, addr[1:0]
//   wdata             - store data (low bits significant for HALF/BYTE)
//   rdata             - raw bus read word
//   be                - byte lane enables (0000 for the UPPER class)
//   wdata_rep         - store data replicated across all lanes
//   rdata_ext         - selected load lane, sign- or zero-extended
module lsu_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane select, enables, store replication and load extension
  always_comb begin
    rbyte     = 8'h00;
    rhalf     = 16'h0000;
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    rdata_ext = 32'h0000_0000;

    case (lane)
      2'b00:   rbyte = rdata[7:0];
      2'b01:   rbyte = rdata[15:8];
      2'b10:   rbyte = rdata[23:16];
      2'b11:   rbyte = rdata[31:24];
      default: rbyte = 8'h00;
    endcase

    // A halfword only ever sits in the low or high half of the word.
    if (lane[1]) begin
      rhalf = rdata[31:16];
    end else begin
      rhalf = rdata[15:0];
    end

    case (size)
      FULL: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      HALF: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        if (sign == SIGN) begin
          rdata_ext = {{16{rhalf[15]}}, rhalf};
        end else begin
          rdata_ext = {16'h0000, rhalf};
        end
      end
      BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        if (sign == SIGN) begin
          rdata_ext = {{24{rbyte[7]}}, rbyte};
        end else begin
          rdata_ext = {24'h00_0000, rbyte};
        end
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        rdata_ext = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/cpu_lsu_ctrl.sv
// cpu_lsu_ctrl
// Load/store sequencer between EX and the data-memory bus. Accepts one memory
// command at a time in IDLE, runs a req/ack handshake with timeout, stalls the
// pipeline while the access is outstanding and returns extended load data.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   cmd, be, sx_sign, addr, wdata, rd - command from decode/EX
//   mem_req/we/addr/be/wdata          - registered bus request, held until ack
//   mem_ack, mem_rdata, mem_err       - bus completion
//   stall                             - freeze IF/ID/EX
//   wb_valid, wb_data, wb_rd          - one-cycle load writeback
//   exc, exc_code                     - one-cycle exception pulse and cause
module cpu_lsu_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cmd,
  input  logic [1:0]    be,
  input  logic          sx_sign,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [4:0]    rd,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_err,
  output logic          stall,
  output logic          wb_valid,
  output logic [31:0]   wb_data,
  output logic [4:0]    wb_rd,
  output logic          exc,
  output logic [1:0]    exc_code
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [1:0]    size_q;
  logic          sign_q;
  logic [1:0]    lane_q;
  logic [4:0]    rd_q;

  logic          mem_op;
  logic          illegal;
  logic          misalign;
  logic          accept;
  logic [1:0]    al_size;
  logic          al_sign;
  logic [1:0]    al_lane;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_rdata;

  // Command decode, accept condition and pipeline stall
  always_comb begin
    mem_op   = (cmd == LW_CMD) || (cmd == ST_CMD);
    illegal  = (be == UPPER);
    misalign = is_misaligned(be, addr[1:0]);
    accept   = (state == IDLE) && mem_op && !illegal && !misalign;
    stall    = accept || (state == REQ);
  end

  // The aligner sees live inputs while accepting and the captured access
  // afterwards, so one instance serves both store packing and load extraction.
  always_comb begin
    if (state == IDLE) begin
      al_size = be;
      al_sign = sx_sign;
      al_lane = addr[1:0];
    end else begin
      al_size = size_q;
      al_sign = sign_q;
      al_lane = lane_q;
    end
  end

  lsu_lane_align u_align (
    .size      (al_size),
    .sign      (al_sign),
    .lane      (al_lane),
    .wdata     (wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  // Sequencer state, bus request registers, writeback and exception pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= {CW{1'b0}};
      size_q    <= 2'b00;
      sign_q    <= 1'b0;
      lane_q    <= 2'b00;
      rd_q      <= 5'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      wb_valid  <= 1'b0;
      wb_data   <= 32'h0000_0000;
      wb_rd     <= 5'd0;
      exc       <= 1'b0;
      exc_code  <= 2'b00;
    end else begin
      wb_valid <= 1'b0;
      exc      <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op && illegal) begin
            exc      <= 1'b1;
            exc_code <= EXC_ILLEGAL;
          end else if (mem_op && misalign) begin
            exc      <= 1'b1;
            exc_code <= EXC_MISALIGN;
          end else if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= (cmd == ST_CMD);
            mem_addr  <= {addr[AW-1:2], 2'b00};
            mem_be    <= al_be;
            mem_wdata <= al_wdata;
            rd_q      <= rd;
            size_q    <= be;
            sign_q    <= sx_sign;
            lane_q    <= addr[1:0];
            cnt       <= {CW{1'b0}};
            state     <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still completes the access.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_err) begin
              exc      <= 1'b1;
              exc_code <= EXC_BUSERR;
              state    <= IDLE;
            end else if (mem_we) begin
              state <= IDLE;
            end else begin
              wb_valid <= 1'b1;
              wb_data  <= al_rdata;
              wb_rd    <= rd_q;
              state    <= RESP;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            exc      <= 1'b1;
            exc_code <= EXC_TIMEOUT;
            state    <= IDLE;
          end else begin
            if (cnt != {CW{1'b1}}) begin
              cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            end else begin
              cnt <= cnt;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_lsu_ctrl.sv
// tb_cpu_lsu_ctrl
// Directed self-checking bench for cpu_lsu_ctrl. Inputs change 1 time unit
// after the rising edge; outputs are checked 1 unit later, mid-cycle.
module tb_cpu_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic [1:0]  be;
  logic        sx_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        exc;
  logic [1:0]  exc_code;

  int checks = 0;
  int failures = 0;
  int stall_total = 0;
  int req_total = 0;
  int snap_stall;
  int snap_req;

  cpu_lsu_ctrl #(.TIMEOUT(16), .AW(32)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .be(be), .sx_sign(sx_sign),
    .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .exc(exc), .exc_code(exc_code)
  );

  always #5 clk = ~clk;

  // Count stalled and requesting cycles mid-cycle
  always @(negedge clk) begin
    if (stall === 1'b1) stall_total <= stall_total + 1;
    if (mem_req === 1'b1) req_total <= req_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] b, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    cmd = c; be = b; sx_sign = s; addr = a; wdata = d; rd = r;
  endtask

  task automatic quiet();
    cmd = 2'b00; be = 2'b00; sx_sign = 1'b0; addr = 32'h0; wdata = 32'h0; rd = 5'd0;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
    quiet();
    cyc(); cyc();
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_exc", {31'd0, exc}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    rst = 1'b0;

    // LB sign-extended at 0x103, ack in the 3rd REQ cycle
    cyc(); snap_stall = stall_total;
    drive(2'b11, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 5'd5);
    #1; chk("lb_accept_stall", {31'd0, stall}, 32'd1);
    cyc(); quiet(); #1;
    chk("lb_req", {31'd0, mem_req}, 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    chk("lb_be", {28'd0, mem_be}, 32'h8);
    chk("lb_we", {31'd0, mem_we}, 32'd0);
    cyc(); #1; chk("lb_req2", {31'd0, mem_req}, 32'd1);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h80FF_FF12;
    cyc(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
    chk("lb_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lb_wbdata", wb_data, 32'hFFFF_FF80);
    chk("lb_wbrd", {27'd0, wb_rd}, 32'd5);
    chk("lb_resp_stall", {31'd0, stall}, 32'd0);
    chk("lb_resp_req", {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    chk("lb_wbv_pulse", {31'd0, wb_valid}, 32'd0);
    chk("lb_stall_cycles", stall_total - snap_stall, 32'd4);

    // LHU at 0x202 then SW at 0x204
    drive(2'b11, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 5'd7);
    cyc(); quiet(); #1;
    chk("lhu_be", {28'd0, mem_be}, 32'hC);
    chk("lhu_addr", mem_addr, 32'h0000_0200);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF_1234;
    cyc(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
    chk("lhu_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lhu_wbdata", wb_data, 32'h0000_BEEF);
    chk("lhu_wbrd", {27'd0, wb_rd}, 32'd7);
    cyc();
    drive(2'b10, 2'b00, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 5'd9);
    #1; chk("sw_accept_stall", {31'd0, stall}, 32'd1);
    cyc(); quiet(); #1;
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_be", {28'd0, mem_be}, 32'hF);
    chk("sw_addr", mem_addr, 32'h0000_0204);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0; #1;
    chk("sw_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("sw_req_drop", {31'd0, mem_req}, 32'd0);
    chk("sw_stall_drop", {31'd0, stall}, 32'd0);

    // SB at 0x301 with immediate ack: 2 stall cycles
    cyc(); snap_stall = stall_total;
    drive(2'b10, 2'b10, 1'b0, 32'h0000_0301, 32'h0000_00A5, 5'd0);
    cyc(); quiet(); #1;
    chk("sb_be", {28'd0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0; #1;
    chk("sb_req_drop", {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    chk("sb_stall_cycles", stall_total - snap_stall, 32'd2);

    // Misaligned LW at 0x002
    snap_req = req_total;
    drive(2'b11, 2'b00, 1'b0, 32'h0000_0002, 32'h0, 5'd1);
    #1; chk("mis_stall", {31'd0, stall}, 32'd0);
    cyc(); quiet(); #1;
    chk("mis_exc", {31'd0, exc}, 32'd1);
    chk("mis_code", {30'd0, exc_code}, 32'd0);
    cyc(); #1;
    chk("mis_exc_pulse", {31'd0, exc}, 32'd0);
    chk("mis_no_req", req_total - snap_req, 32'd0);

    // Illegal size class
    drive(2'b11, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 5'd1);
    cyc(); quiet(); #1;
    chk("ill_exc", {31'd0, exc}, 32'd1);
    chk("ill_code", {30'd0, exc_code}, 32'd1);
    chk("ill_req", {31'd0, mem_req}, 32'd0);

    // Jump command: no action
    cyc();
    drive(2'b01, 2'b00, 1'b0, 32'h0000_0020, 32'h0, 5'd1);
    #1; chk("jmp_stall", {31'd0, stall}, 32'd0);
    cyc(); quiet(); #1;
    chk("jmp_req", {31'd0, mem_req}, 32'd0);
    chk("jmp_exc", {31'd0, exc}, 32'd0);

    // Timeout: 16 REQ cycles with no ack, then a stray ack
    drive(2'b11, 2'b00, 1'b0, 32'h0000_0400, 32'h0, 5'd3);
    for (int i = 0; i < 16; i++) begin
      cyc(); quiet(); #1;
      chk("to_req_held", {31'd0, mem_req}, 32'd1);
    end
    cyc(); #1;
    chk("to_exc", {31'd0, exc}, 32'd1);
    chk("to_code", {30'd0, exc_code}, 32'd2);
    chk("to_req", {31'd0, mem_req}, 32'd0);
    chk("to_stall", {31'd0, stall}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    cyc(); mem_ack = 1'b0; #1;
    chk("to_stray_wb", {31'd0, wb_valid}, 32'd0);
    chk("to_stray_req", {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    chk("to_stray_wb2", {31'd0, wb_valid}, 32'd0);

    // Bus error
    drive(2'b11, 2'b00, 1'b0, 32'h0000_0500, 32'h0, 5'd4);
    cyc(); quiet(); mem_ack = 1'b1; mem_err = 1'b1;
    cyc(); mem_ack = 1'b0; mem_err = 1'b0; #1;
    chk("err_exc", {31'd0, exc}, 32'd1);
    chk("err_code", {30'd0, exc_code}, 32'd3);
    chk("err_wb", {31'd0, wb_valid}, 32'd0);
    chk("err_req", {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    chk("err_wb2", {31'd0, wb_valid}, 32'd0);

    // Reset in the 2nd REQ cycle, then a late ack
    drive(2'b11, 2'b00, 1'b0, 32'h0000_0600, 32'h0, 5'd6);
    cyc(); quiet();
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_exc", {31'd0, exc}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    cyc(); mem_ack = 1'b0; #1;
    chk("rst_late_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_late_req", {31'd0, mem_req}, 32'd0);

    // Back in IDLE: LBU at 0x102 accepted normally
    drive(2'b11, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 5'd10);
    #1; chk("lbu_accept_stall", {31'd0, stall}, 32'd1);
    cyc(); quiet(); #1;
    chk("lbu_be", {28'd0, mem_be}, 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'h1180_2233;
    cyc(); mem_ack = 1'b0; #1;
    chk("lbu_wbdata", wb_data, 32'h0000_0080);
    chk("lbu_wbrd", {27'd0, wb_rd}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
